// File: rtl/program_loader_pkg.sv
// Shared word and address types for the program loader and its neighbours.
// ISA_WIDTH and RAM_DEPTH track the rest of the core.
package program_loader_pkg;

   localparam int unsigned ISA_WIDTH = 32;
   localparam int unsigned RAM_DEPTH = 14;
   localparam int unsigned LOAD_AW   = RAM_DEPTH + 1;

   typedef logic [ISA_WIDTH-1:0] word_t;
   typedef logic [LOAD_AW-1:0]   load_addr_t;
   typedef logic [RAM_DEPTH-1:0] mem_addr_t;

   // Load address MSB picks data memory over instruction memory.
   function automatic logic is_dmem(input load_addr_t addr);
      return addr[LOAD_AW-1];
   endfunction

   function automatic mem_addr_t mem_index(input load_addr_t addr);
      return addr[RAM_DEPTH-1:0];
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Programming stream from the debug unit plus the loader's memory-write and status outputs.
// master = stream producer side, slave = the loader.
interface program_loader_if
   import program_loader_pkg::*;
;
   logic       load_we;
   load_addr_t load_addr;
   word_t      load_data;
   logic       load_done;

   logic       imem_we;
   mem_addr_t  imem_addr;
   word_t      imem_wdata;
   logic       dmem_we;
   mem_addr_t  dmem_addr;
   word_t      dmem_wdata;
   logic       cpu_hold;
   logic       cpu_restart;
   logic       load_active;
   load_addr_t word_count;
   word_t      checksum;
   logic       load_error;

   modport master (
      output load_we, load_addr, load_data, load_done,
      input  imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
      input  cpu_hold, cpu_restart, load_active, word_count, checksum, load_error
   );

   modport slave (
      input  load_we, load_addr, load_data, load_done,
      output imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata,
      output cpu_hold, cpu_restart, load_active, word_count, checksum, load_error
   );

endinterface

// File: rtl/program_loader.sv
// Steers the debug unit's word stream into imem/dmem, tracks session status, and
// holds then restarts the CPU once the new image is in place.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned RESTART_HOLD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   program_loader_if.slave io_bus
);

   localparam int unsigned      CNT_W    = (RESTART_HOLD > 1) ? $clog2(RESTART_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTART_HOLD - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_RESTART = 2'd2;

   logic [1:0]       r_state, w_state;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   load_addr_t       r_exp_addr, w_exp_addr;
   load_addr_t       r_word_count, w_word_count;
   word_t            r_checksum, w_checksum;
   logic             r_error, w_error;
   logic             w_accept;
   logic             w_to_dmem;

   logic             r_imem_we, r_dmem_we;
   mem_addr_t        r_imem_addr, r_dmem_addr;
   word_t            r_imem_wdata, r_dmem_wdata;
   logic             r_hold, r_restart, r_active;

   assign w_to_dmem = is_dmem(io_bus.load_addr);

   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_exp_addr   = r_exp_addr;
      w_word_count = r_word_count;
      w_checksum   = r_checksum;
      w_error      = r_error;
      w_accept     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.load_we) begin
               // New session: a well-formed image always starts at address 0.
               w_state      = ST_LOAD;
               w_accept     = 1'b1;
               w_word_count = LOAD_AW'(1);
               w_checksum   = io_bus.load_data;
               w_error      = (io_bus.load_addr != '0);
               w_exp_addr   = io_bus.load_addr + LOAD_AW'(1);
               if (io_bus.load_done) begin
                  w_state = ST_RESTART;
                  w_cnt   = CNT_LOAD;
               end
            end else if (io_bus.load_done) begin
               w_state      = ST_RESTART;
               w_cnt        = CNT_LOAD;
               w_word_count = '0;
               w_checksum   = '0;
               w_error      = 1'b0;
            end
         end
         ST_LOAD: begin
            if (io_bus.load_we) begin
               w_accept     = 1'b1;
               w_word_count = r_word_count + LOAD_AW'(1);
               w_checksum   = r_checksum + io_bus.load_data;
               w_exp_addr   = io_bus.load_addr + LOAD_AW'(1);
               if (io_bus.load_addr != r_exp_addr) begin
                  w_error = 1'b1;
               end
            end
            if (io_bus.load_done) begin
               w_state = ST_RESTART;
               w_cnt   = CNT_LOAD;
            end
         end
         ST_RESTART: begin
            // Writes arriving while the CPU restarts are dropped and flagged.
            if (io_bus.load_we) begin
               w_error = 1'b1;
            end
            if (r_cnt == '0) begin
               w_state = ST_IDLE;
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_exp_addr   <= '0;
         r_word_count <= '0;
         r_checksum   <= '0;
         r_error      <= 1'b0;
         r_imem_we    <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_dmem_addr  <= '0;
         r_imem_wdata <= '0;
         r_dmem_wdata <= '0;
         r_hold       <= 1'b0;
         r_restart    <= 1'b0;
         r_active     <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_cnt        <= w_cnt;
         r_exp_addr   <= w_exp_addr;
         r_word_count <= w_word_count;
         r_checksum   <= w_checksum;
         r_error      <= w_error;
         r_imem_we    <= w_accept && !w_to_dmem;
         r_dmem_we    <= w_accept && w_to_dmem;
         if (w_accept && !w_to_dmem) begin
            r_imem_addr  <= mem_index(io_bus.load_addr);
            r_imem_wdata <= io_bus.load_data;
         end
         if (w_accept && w_to_dmem) begin
            r_dmem_addr  <= mem_index(io_bus.load_addr);
            r_dmem_wdata <= io_bus.load_data;
         end
         r_hold       <= (w_state != ST_IDLE);
         r_restart    <= (w_state == ST_RESTART);
         r_active     <= (w_state == ST_LOAD);
      end
   end

   assign io_bus.imem_we     = r_imem_we;
   assign io_bus.imem_addr   = r_imem_addr;
   assign io_bus.imem_wdata  = r_imem_wdata;
   assign io_bus.dmem_we     = r_dmem_we;
   assign io_bus.dmem_addr   = r_dmem_addr;
   assign io_bus.dmem_wdata  = r_dmem_wdata;
   assign io_bus.cpu_hold    = r_hold;
   assign io_bus.cpu_restart = r_restart;
   assign io_bus.load_active = r_active;
   assign io_bus.word_count  = r_word_count;
   assign io_bus.checksum    = r_checksum;
   assign io_bus.load_error  = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Random and directed programming sessions against a session-level reference model,
// compared on every falling clock edge.
module tb_program_loader;
   import program_loader_pkg::*;

   localparam int HOLD     = 4;
   localparam int PH_IDLE  = 0;
   localparam int PH_LOAD  = 1;
   localparam int PH_RST   = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   program_loader_if bus ();

   program_loader #(.RESTART_HOLD(HOLD)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: a session begins at the first write after idle and expects
   // addresses 0,1,2,...; a finished session restarts the CPU for HOLD cycles.
   int         m_phase = PH_IDLE;
   int         m_left  = 0;
   load_addr_t m_next  = '0;
   load_addr_t m_count = '0;
   word_t      m_sum   = '0;
   logic       m_err   = 1'b0;
   logic       e_iwe = 1'b0, e_dwe = 1'b0;
   mem_addr_t  e_iaddr = '0, e_daddr = '0;
   word_t      e_idata = '0, e_ddata = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = PH_IDLE; m_left = 0; m_next = '0; m_count = '0; m_sum = '0; m_err = 1'b0;
         e_iwe = 1'b0; e_dwe = 1'b0; e_iaddr = '0; e_daddr = '0; e_idata = '0; e_ddata = '0;
      end else begin
         e_iwe = 1'b0;
         e_dwe = 1'b0;
         if (m_phase == PH_RST) begin
            if (bus.load_we) m_err = 1'b1;
            m_left--;
            if (m_left == 0) m_phase = PH_IDLE;
         end else begin
            if (bus.load_we) begin
               if (m_phase == PH_IDLE) begin
                  m_count = '0; m_sum = '0; m_err = 1'b0; m_next = '0; m_phase = PH_LOAD;
               end
               if (bus.load_addr != m_next) m_err = 1'b1;
               m_count = m_count + 1'b1;
               m_sum   = m_sum + bus.load_data;
               m_next  = bus.load_addr + 1'b1;
               if (bus.load_addr[LOAD_AW-1]) begin
                  e_dwe = 1'b1; e_daddr = bus.load_addr[RAM_DEPTH-1:0]; e_ddata = bus.load_data;
               end else begin
                  e_iwe = 1'b1; e_iaddr = bus.load_addr[RAM_DEPTH-1:0]; e_idata = bus.load_data;
               end
            end
            if (bus.load_done) begin
               if (m_phase == PH_IDLE) begin
                  m_count = '0; m_sum = '0; m_err = 1'b0;
               end
               m_phase = PH_RST;
               m_left  = HOLD;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("imem_we",     64'(bus.imem_we),     64'(e_iwe));
      chk("imem_addr",   64'(bus.imem_addr),   64'(e_iaddr));
      chk("imem_wdata",  64'(bus.imem_wdata),  64'(e_idata));
      chk("dmem_we",     64'(bus.dmem_we),     64'(e_dwe));
      chk("dmem_addr",   64'(bus.dmem_addr),   64'(e_daddr));
      chk("dmem_wdata",  64'(bus.dmem_wdata),  64'(e_ddata));
      chk("cpu_hold",    64'(bus.cpu_hold),    64'(m_phase != PH_IDLE));
      chk("cpu_restart", 64'(bus.cpu_restart), 64'(m_phase == PH_RST));
      chk("load_active", 64'(bus.load_active), 64'(m_phase == PH_LOAD));
      chk("word_count",  64'(bus.word_count),  64'(m_count));
      chk("checksum",    64'(bus.checksum),    64'(m_sum));
      chk("load_error",  64'(bus.load_error),  64'(m_err));
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input load_addr_t a, input word_t d, input logic dn);
      bus.load_we   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      bus.load_done = dn;
      step(1);
      bus.load_we   = 1'b0;
      bus.load_done = 1'b0;
   endtask

   task automatic done_pulse();
      bus.load_done = 1'b1;
      step(1);
      bus.load_done = 1'b0;
   endtask

   task automatic count_restart(input string nm);
      int n = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.cpu_restart !== 1'b1) break;
         n++;
         step(1);
      end
      chk(nm, 64'(n), 64'(HOLD));
      chk({nm, "_hold_fall"}, 64'(bus.cpu_hold), 64'(0));
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && bus.cpu_hold; i++) step(1);
      chk("idle_timeout", 64'(bus.cpu_hold), 64'(0));
   endtask

   initial begin
      load_addr_t a;
      logic       dn;
      int         len;
      int         pulses;

      bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.load_done = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #7;
      chk("rst_hold",  64'(bus.cpu_hold),   64'(0));
      chk("rst_count", 64'(bus.word_count), 64'(0));
      chk("rst_imem",  64'(bus.imem_we),    64'(0));
      #4 rst_n = 1'b1;
      step(1);

      // Three sequential instruction words.
      wr(15'd0, 32'h11, 1'b0);
      chk("w0_imem_we", 64'(bus.imem_we), 64'(1));
      chk("w0_wdata", 64'(bus.imem_wdata), 64'(32'h11));
      chk("w0_active", 64'(bus.load_active), 64'(1));
      wr(15'd1, 32'h22, 1'b0);
      wr(15'd2, 32'h33, 1'b0);
      chk("w2_addr", 64'(bus.imem_addr), 64'(2));
      chk("t1_count", 64'(bus.word_count), 64'(3));
      chk("t1_sum", 64'(bus.checksum), 64'(32'h66));
      chk("t1_err", 64'(bus.load_error), 64'(0));
      done_pulse();
      count_restart("t1_restart_len");
      chk("t1_count_idle", 64'(bus.word_count), 64'(3));

      // Steering by MSB.
      wr(15'h0000, 32'hDEADBEEF, 1'b0);
      wr(15'h4000, 32'h1, 1'b0);
      chk("t2_dmem_we", 64'(bus.dmem_we), 64'(1));
      chk("t2_imem_we", 64'(bus.imem_we), 64'(0));
      chk("t2_dmem_addr", 64'(bus.dmem_addr), 64'(0));
      done_pulse();
      chk("t2_sum", 64'(bus.checksum), 64'(32'hDEADBEF0));
      count_restart("t2_restart_len");

      // Address gap raises a sticky error, cleared by the next clean session.
      wr(15'd0, 32'h1, 1'b0);
      wr(15'd1, 32'h2, 1'b0);
      chk("t3_err_pre", 64'(bus.load_error), 64'(0));
      wr(15'd3, 32'h3, 1'b0);
      chk("t3_err", 64'(bus.load_error), 64'(1));
      chk("t3_count", 64'(bus.word_count), 64'(3));
      done_pulse();
      count_restart("t3_restart_len");
      chk("t3_err_idle", 64'(bus.load_error), 64'(1));
      wr(15'd0, 32'h7, 1'b0);
      chk("t3_err_clr", 64'(bus.load_error), 64'(0));
      done_pulse();
      wait_idle();

      // Empty program.
      done_pulse();
      chk("t4_count", 64'(bus.word_count), 64'(0));
      chk("t4_sum", 64'(bus.checksum), 64'(0));
      count_restart("t4_restart_len");

      // Write and done together, then a stray write during restart.
      wr(15'd0, 32'hA, 1'b0);
      wr(15'd1, 32'hB, 1'b1);
      chk("t5_imem_we", 64'(bus.imem_we), 64'(1));
      chk("t5_count", 64'(bus.word_count), 64'(2));
      chk("t5_restart", 64'(bus.cpu_restart), 64'(1));
      wr(15'd2, 32'hC, 1'b0);
      chk("t6_no_write", 64'(bus.imem_we), 64'(0));
      chk("t6_count", 64'(bus.word_count), 64'(2));
      chk("t6_err", 64'(bus.load_error), 64'(1));
      wait_idle();

      // Reset in the middle of a session.
      wr(15'd0, 32'h5, 1'b0);
      wr(15'd1, 32'h6, 1'b0);
      #3 rst_n = 1'b0;
      #2;
      chk("t7_hold", 64'(bus.cpu_hold), 64'(0));
      chk("t7_count", 64'(bus.word_count), 64'(0));
      chk("t7_active", 64'(bus.load_active), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.cpu_restart) pulses++;
         step(1);
      end
      chk("t7_no_restart", 64'(pulses), 64'(0));

      // Random sessions.
      for (int s = 0; s < 40; s++) begin
         step($urandom_range(0, 3));
         len = $urandom_range(0, 6);
         a = '0;
         if ($urandom_range(0, 3) == 0) a = load_addr_t'($urandom);
         dn = 1'b0;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 5) == 0) a = load_addr_t'($urandom);
            dn = (i == len - 1) && (i > 0) && ($urandom_range(0, 2) == 0);
            wr(a, word_t'($urandom), dn);
            a = a + 1'b1;
            if (!dn && $urandom_range(0, 3) == 0) step(1);
         end
         if (!dn) done_pulse();
         if ($urandom_range(0, 2) == 0) wr(load_addr_t'($urandom), word_t'($urandom), 1'b0);
         wait_idle();
      end

      step(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sits directly downstream of the UART debug unit.
- Consumes its programming word stream (address, data, write strobe, completion pulse) and steers each word into instruction memory or data memory by the address MSB.
- Tracks word count, a running checksum and address sequencing for status reporting back to the client.
- Holds the CPU during a load, then issues a timed restart pulse so execution begins cleanly from the new image.

Parameters:
- ISA_WIDTH, 32, data word width (taken from the shared definitions).
- RAM_DEPTH, 14, per-memory word-address width; the load address is RAM_DEPTH+1 bits wide.
- RESTART_HOLD, 4, number of cycles cpu_restart stays high after a load completes (must be ≥1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- load_we  in  1  single-cycle write strobe from the debug unit.
- load_addr  in  RAM_DEPTH+1  word address; MSB=0 selects instruction memory, MSB=1 selects data memory.
- load_data  in  ISA_WIDTH  word to write.
- load_done  in  1  single-cycle pulse: programming transfer finished.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  RAM_DEPTH  instruction memory word address.
- imem_wdata  out  ISA_WIDTH  instruction memory write data.
- dmem_we  out  1  data memory write enable.
- dmem_addr  out  RAM_DEPTH  data memory word address.
- dmem_wdata  out  ISA_WIDTH  data memory write data.
- cpu_hold  out  1  stall request to the hazard unit, high for the whole session.
- cpu_restart  out  1  CPU soft-reset request (pc to 0, pipeline flush).
- load_active  out  1  high while in LOAD.
- word_count  out  RAM_DEPTH+1  words accepted in the current or last session.
- checksum  out  ISA_WIDTH  modulo-2^ISA_WIDTH sum of accepted words.
- load_error  out  1  sticky sequencing or protocol error.

Behaviour:
- Reset is asynchronous and active-low, on rst_n; the clock is clk.
- Reset values:
  - all outputs 0.
  - state IDLE.
  - expected address 0.
  - restart counter 0.
- All outputs are registered.

Write path:
- Latency: load_we in cycle N gives exactly one of imem_we or dmem_we high in cycle N+1.
- The corresponding addr/wdata are valid in that same cycle N+1.
- The write-enable outputs are high for exactly one cycle per accepted strobe.
- imem_addr and dmem_addr are load_addr[RAM_DEPTH-1:0]; wdata is load_data.
- addr/wdata outputs hold their last value when the write enable is low.

FSM states IDLE, LOAD, RESTART:
- IDLE + load_we:
  - go to LOAD and begin a new session.
  - word_count set to 1, checksum set to load_data.
  - load_error cleared, then set if load_addr≠0.
  - the write is performed.
  - expected address set to load_addr+1.
  - cpu_hold and load_active rise in the next cycle.
- IDLE + load_done (empty program): go to RESTART; count and checksum reset to 0; error cleared.
- LOAD + load_we:
  - write performed; word_count+1; checksum+=load_data.
  - if load_addr≠expected address, load_error is set; the write still proceeds.
  - expected address set to load_addr+1, wrapping modulo 2^(RAM_DEPTH+1).
- LOAD + load_done:
  - go to RESTART; restart counter loaded with RESTART_HOLD-1.
  - a load_we in the same cycle is written and counted first.
- RESTART:
  - cpu_restart=1 and cpu_hold=1 for exactly RESTART_HOLD cycles.
  - when the counter reaches 0, go to IDLE; cpu_restart and cpu_hold fall together.
  - load_we here is dropped (no memory write, no count) and sets load_error.
  - load_done here is ignored.
- word_count and checksum wrap silently and stay readable in IDLE until the next session starts.
- Reset mid-session: all outputs clear immediately; memories keep the words already written; no restart pulse is issued.

Decomposition:
- ISA_WIDTH and RAM_DEPTH come from the shared definitions file.
- State encodings and RESTART_HOLD are local.
- No sub-module: the restart timer and address steering are small enough to stay inline.

Test Plan:
- Three words 0x11,0x22,0x33 to addrs 0,1,2 then load_done:
  - imem_we pulses at addrs 0,1,2.
  - word_count=3, checksum=0x66, load_error=0.
  - cpu_restart high for 4 cycles, then cpu_hold low.
- Addr 0x0000 then 0x4000, data 0xDEADBEEF/0x1:
  - one imem write at 0, one dmem write at 0.
  - checksum=0xDEADBEF0.
- Addrs 0,1,3: all three written; load_error=1 after the third; cleared by the next session starting at addr 0.
- load_done with no prior load_we: count=0, checksum=0, 4-cycle restart pulse, no memory writes.
- load_we and load_done in the same cycle in LOAD: that word is written and counted, then RESTART.
- Extra load_we during RESTART: no write, word_count unchanged, load_error=1.
- rst_n low mid-LOAD: all outputs 0 asynchronously; cpu_restart never pulses.
